// File: rtl/char_text_buffer_pkg.sv
// Shared character codes, char_xy field layout and FSM state type for the
// runtime-writable text buffer.
package char_text_buffer_pkg;

   localparam logic [6:0] CHAR_BLANK   = 7'h20;
   localparam logic [6:0] CHAR_NEWLINE = 7'h0A;
   localparam logic [6:0] CHAR_NULL    = 7'h00;

   localparam int unsigned CHAR_COL_MSB = 7;
   localparam int unsigned CHAR_COL_LSB = 4;
   localparam int unsigned CHAR_ROW_MSB = 3;
   localparam int unsigned CHAR_ROW_LSB = 0;

   typedef enum logic {
      IDLE,
      CLEAR
   } ctb_state_t;

   function automatic logic [3:0] inc_wrap(input logic [3:0] v, input logic [3:0] last);
      return (v == last) ? 4'd0 : v + 4'd1;
   endfunction

endpackage

// File: rtl/char_text_buffer_ram.sv
// Character storage: synchronous write, asynchronous read, addressed by
// {column,row}; only NUM_COLS*16 entries exist.
module char_ram #(
   parameter int unsigned NUM_COLS = 7
) (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] wr_addr,
   input  logic [6:0] wr_data,
   input  logic [7:0] rd_addr,
   output logic [6:0] rd_data
);

   localparam int unsigned DEPTH  = NUM_COLS * 16;
   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam logic [8:0]  DEPTH_W = 9'(DEPTH);

   logic [6:0] mem [DEPTH];
   logic       wr_ok;
   logic       rd_ok;

   assign wr_ok = ({1'b0, wr_addr} < DEPTH_W);
   assign rd_ok = ({1'b0, rd_addr} < DEPTH_W);

   always_ff @(posedge clk) begin
      if (we && wr_ok) begin
         mem[wr_addr[ADDR_W-1:0]] <= wr_data;
      end
   end

   assign rd_data = rd_ok ? mem[rd_addr[ADDR_W-1:0]] : '0;

endmodule

// File: rtl/char_text_buffer.sv
// Cursor-driven writable text buffer feeding the char_xy -> char_code read
// interface; a clear sequence fills every cell with FILL_CHAR after reset.
module char_text_buffer
   import char_text_buffer_pkg::*;
#(
   parameter int unsigned TEXT_SIZE_X  = 7,
   parameter int unsigned TEXT_SIZE_Y  = 1,
   parameter logic [6:0]  FILL_CHAR    = CHAR_BLANK,
   parameter logic [6:0]  NEWLINE_CHAR = CHAR_NEWLINE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_req,
   input  logic       set_pos,
   input  logic [3:0] set_x,
   input  logic [3:0] set_y,
   input  logic       wr_valid,
   input  logic [6:0] wr_char,
   output logic       wr_ready,
   output logic       busy,
   input  logic [7:0] char_xy,
   output logic [6:0] char_code
);

   localparam int unsigned N     = TEXT_SIZE_X * TEXT_SIZE_Y;
   localparam int unsigned CNT_W = $clog2(N + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
   localparam logic [3:0]       X_LAST   = 4'(TEXT_SIZE_X - 1);
   localparam logic [3:0]       Y_LAST   = 4'(TEXT_SIZE_Y - 1);
   localparam logic [4:0]       X_LIM    = 5'(TEXT_SIZE_X);
   localparam logic [4:0]       Y_LIM    = 5'(TEXT_SIZE_Y);

   ctb_state_t       state, state_nxt;
   logic [CNT_W-1:0] clr_cnt, clr_cnt_nxt;
   logic [3:0]       clr_x, clr_x_nxt, clr_y, clr_y_nxt;
   logic [3:0]       cur_x, cur_x_nxt, cur_y, cur_y_nxt;

   logic       ram_we;
   logic [7:0] ram_wr_addr;
   logic [6:0] ram_wr_data;
   logic [6:0] ram_rd_data;
   logic       rd_in_range;
   logic       set_in_range;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         clr_x   <= '0;
         clr_y   <= '0;
         cur_x   <= '0;
         cur_y   <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
         clr_x   <= clr_x_nxt;
         clr_y   <= clr_y_nxt;
         cur_x   <= cur_x_nxt;
         cur_y   <= cur_y_nxt;
      end
   end

   assign set_in_range = ({1'b0, set_x} < X_LIM) && ({1'b0, set_y} < Y_LIM);
   assign wr_ready     = (state == IDLE) & ~clear_req & ~set_pos;
   assign busy         = (state == CLEAR);

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      clr_x_nxt   = clr_x;
      clr_y_nxt   = clr_y;
      cur_x_nxt   = cur_x;
      cur_y_nxt   = cur_y;
      ram_we      = 1'b0;
      ram_wr_addr = {cur_x, cur_y};
      ram_wr_data = wr_char;

      unique case (state)
         CLEAR: begin
            ram_we      = 1'b1;
            ram_wr_addr = {clr_x, clr_y};
            ram_wr_data = FILL_CHAR;
            // clr_x/clr_y track clr_cnt so no divider is needed for the address
            if (clear_req) begin
               clr_cnt_nxt = '0;
               clr_x_nxt   = '0;
               clr_y_nxt   = '0;
            end else if (clr_cnt == CNT_LAST) begin
               state_nxt = IDLE;
            end else begin
               clr_cnt_nxt = clr_cnt + 1'b1;
               clr_x_nxt   = inc_wrap(clr_x, X_LAST);
               if (clr_x == X_LAST) begin
                  clr_y_nxt = clr_y + 4'd1;
               end
            end
         end

         IDLE: begin
            if (clear_req) begin
               state_nxt   = CLEAR;
               clr_cnt_nxt = '0;
               clr_x_nxt   = '0;
               clr_y_nxt   = '0;
               cur_x_nxt   = '0;
               cur_y_nxt   = '0;
            end else if (set_pos) begin
               if (set_in_range) begin
                  cur_x_nxt = set_x;
                  cur_y_nxt = set_y;
               end
            end else if (wr_valid) begin
               if (wr_char == NEWLINE_CHAR) begin
                  cur_x_nxt = '0;
                  cur_y_nxt = inc_wrap(cur_y, Y_LAST);
               end else begin
                  ram_we    = 1'b1;
                  cur_x_nxt = inc_wrap(cur_x, X_LAST);
                  if (cur_x == X_LAST) begin
                     cur_y_nxt = inc_wrap(cur_y, Y_LAST);
                  end
               end
            end
         end

         default: state_nxt = CLEAR;
      endcase
   end

   char_ram #(
      .NUM_COLS (TEXT_SIZE_X)
   ) u_char_ram (
      .clk     (clk),
      .we      (ram_we),
      .wr_addr (ram_wr_addr),
      .wr_data (ram_wr_data),
      .rd_addr (char_xy),
      .rd_data (ram_rd_data)
   );

   assign rd_in_range = ({1'b0, char_xy[CHAR_COL_MSB:CHAR_COL_LSB]} < X_LIM) &&
                        ({1'b0, char_xy[CHAR_ROW_MSB:CHAR_ROW_LSB]} < Y_LIM);
   assign char_code   = rd_in_range ? ram_rd_data : CHAR_NULL;

endmodule

// File: tb/tb_char_text_buffer.sv
// Directed self-checking bench for char_text_buffer in a 4x2 configuration.
module tb_char_text_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear_req;
   logic       set_pos;
   logic [3:0] set_x;
   logic [3:0] set_y;
   logic       wr_valid;
   logic [6:0] wr_char;
   logic       wr_ready;
   logic       busy;
   logic [7:0] char_xy;
   logic [6:0] char_code;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   char_text_buffer #(
      .TEXT_SIZE_X  (4),
      .TEXT_SIZE_Y  (2),
      .FILL_CHAR    (7'h20),
      .NEWLINE_CHAR (7'h0A)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clear_req (clear_req),
      .set_pos   (set_pos),
      .set_x     (set_x),
      .set_y     (set_y),
      .wr_valid  (wr_valid),
      .wr_char   (wr_char),
      .wr_ready  (wr_ready),
      .busy      (busy),
      .char_xy   (char_xy),
      .char_code (char_code)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cell(input string tag, input logic [7:0] a, input logic [6:0] exp);
      char_xy = a;
      #1;
      check(tag, 32'(char_code), 32'(exp));
   endtask

   task automatic check_all_fill(input string tag);
      for (int x = 0; x < 4; x++)
         for (int y = 0; y < 2; y++)
            check_cell($sformatf("%s_cell_%0d%0d", tag, x, y), {4'(x), 4'(y)}, 7'h20);
   endtask

   // Entered just after the edge that put the DUT into CLEAR.
   task automatic wait_clear(input string tag);
      int n = 0;
      int ready_bad = 0;
      while (busy && n < 40) begin
         if (wr_ready) ready_bad++;
         n++;
         tick();
      end
      check({tag, "_busy_cycles"}, 32'(n), 32'd8);
      check({tag, "_ready_low"}, 32'(ready_bad), 32'd0);
      check({tag, "_idle_flags"}, {30'd0, busy, wr_ready}, 32'b01);
   endtask

   task automatic write_char(input logic [6:0] c);
      wr_valid = 1'b1;
      wr_char  = c;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic write_str(input string s);
      for (int i = 0; i < s.len(); i++) write_char(7'(s[i]));
   endtask

   task automatic set_cursor(input logic [3:0] x, input logic [3:0] y);
      set_pos = 1'b1;
      set_x   = x;
      set_y   = y;
      tick();
      set_pos = 1'b0;
   endtask

   initial begin
      int nl_cells;

      rst = 1'b1; clear_req = 1'b0; set_pos = 1'b0; set_x = '0; set_y = '0;
      wr_valid = 1'b0; wr_char = '0; char_xy = '0;
      tick();
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd1);
      wait_clear("rst");
      check_all_fill("rst");
      check_cell("oob_col", 8'h40, 7'h00);
      check_cell("oob_row", 8'h02, 7'h00);

      // Same-cycle read of the cell being written returns the old value.
      char_xy  = 8'h00;
      wr_valid = 1'b1;
      wr_char  = 7'h53;
      #1;
      check("rd_before_wr", 32'(char_code), 32'h20);
      tick();
      wr_valid = 1'b0;
      write_str("ky");
      check_cell("sky_S", 8'h00, 7'h53);
      check_cell("sky_k", 8'h10, 7'h6B);
      check_cell("sky_y", 8'h20, 7'h79);
      write_char(7'h78);
      check_cell("sky_cursor", 8'h30, 7'h78);

      set_cursor(4'd0, 4'd0);
      write_str("ABCDEFGHI");
      check_cell("wrap_D", 8'h30, 7'h44);
      check_cell("wrap_E", 8'h01, 7'h45);
      check_cell("wrap_H", 8'h31, 7'h48);
      check_cell("wrap_I", 8'h00, 7'h49);

      set_cursor(4'd2, 4'd0);
      write_char(7'h0A);
      write_char(7'h5A);
      check_cell("nl_Z", 8'h01, 7'h5A);
      check_cell("nl_keep", 8'h20, 7'h43);
      nl_cells = 0;
      for (int x = 0; x < 4; x++)
         for (int y = 0; y < 2; y++) begin
            char_xy = {4'(x), 4'(y)};
            #1;
            if (char_code == 7'h0A) nl_cells++;
         end
      check("nl_not_stored", 32'(nl_cells), 32'd0);

      set_cursor(4'd3, 4'd0);
      set_pos = 1'b1; set_x = 4'd1; set_y = 4'd1;
      wr_valid = 1'b1; wr_char = 7'h51;
      #1;
      check("setpos_blocks_ready", 32'(wr_ready), 32'd0);
      tick();
      set_pos = 1'b0; wr_valid = 1'b0;
      check_cell("setpos_no_store_old", 8'h30, 7'h44);
      check_cell("setpos_no_store_new", 8'h11, 7'h46);
      write_char(7'h52);
      check_cell("setpos_cursor", 8'h11, 7'h52);

      set_cursor(4'd5, 4'd0);
      write_char(7'h54);
      check_cell("setpos_x_oob", 8'h21, 7'h54);
      set_cursor(4'd0, 4'd2);
      write_char(7'h55);
      check_cell("setpos_y_oob", 8'h31, 7'h55);

      clear_req = 1'b1; set_pos = 1'b1; set_x = 4'd2; set_y = 4'd1;
      wr_valid = 1'b1; wr_char = 7'h57;
      #1;
      check("clr_blocks_ready", 32'(wr_ready), 32'd0);
      tick();
      clear_req = 1'b0; set_pos = 1'b0; wr_valid = 1'b0;
      wait_clear("clr");
      check_all_fill("clr");
      write_char(7'h56);
      check_cell("clr_cursor", 8'h00, 7'h56);
      check_cell("clr_not_setpos", 8'h21, 7'h20);

      write_str("mn");
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (3) tick();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      wait_clear("restart");
      check_all_fill("restart");

      write_str("ab");
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_clear("rst_clr");
      check_all_fill("rst_clr");
      write_char(7'h63);
      check_cell("rst_clr_cursor", 8'h00, 7'h63);

      write_str("de");
      wr_valid = 1'b1; wr_char = 7'h65;
      rst = 1'b1;
      tick();
      rst = 1'b0; wr_valid = 1'b0;
      wait_clear("rst_wr");
      check_all_fill("rst_wr");
      write_char(7'h66);
      check_cell("rst_wr_cursor", 8'h00, 7'h66);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
